// File: rtl/overlay_sdram_sched.sv
// SDRAM channel-1 scheduler for the overlay: byte-paired download writes always win over
// the 32-bit pixel prefetch reads, whose FIFO is restarted from address 0 on every VSync.
module overlay_sdram_sched #(
  parameter int ADDR_W     = 24,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              sdram_present,
  input  logic              dl_active,
  input  logic              dl_wr,
  input  logic [24:0]       dl_addr,
  input  logic [7:0]        dl_data,
  input  logic              ce_pix,
  input  logic              hblank,
  input  logic              vblank,
  input  logic              vsync,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [15:0]       mem_din,
  output logic              mem_req,
  output logic              mem_rnw,
  input  logic [31:0]       mem_dout,
  input  logic              mem_ack,
  output logic              use_bg,
  output logic [15:0]       pix_out,
  output logic              underrun,
  output logic              dl_overrun
);
  localparam int PW = $clog2(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, WR_WAIT, RD_WAIT} state_t;

  state_t            state_q;
  logic              use_bg_q, vsync_q, epoch_q, rd_epoch_q, half_q;
  logic [7:0]        lat_q;
  logic              slot_full_q;
  logic [ADDR_W-1:0] slot_addr_q, fetch_addr_q, mem_addr_q;
  logic [15:0]       slot_data_q, mem_din_q, pix_q;
  logic              mem_req_q, mem_rnw_q, underrun_q, dl_overrun_q;
  logic [PW-1:0]     wr_ptr_q, rd_ptr_q;
  logic [PW:0]       count_q, count_d;
  logic [31:0]       fifo_mem [FIFO_DEPTH];
  logic [31:0]       head;

  logic fetch_en, restart, consume, fifo_empty, fifo_full;
  logic new_wr, issue_wr, issue_rd, rd_done, push, pop, flush;

  assign fetch_en   = use_bg_q & ~dl_active;
  assign restart    = vsync & ~vsync_q & fetch_en;
  assign consume    = ce_pix & ~hblank & ~vblank & fetch_en;
  assign fifo_empty = (count_q == '0);
  // No read can be in flight while IDLE, so the occupancy alone bounds the next issue.
  assign fifo_full  = (count_q == (PW+1)'(FIFO_DEPTH));
  assign new_wr     = dl_wr & dl_addr[0];
  assign issue_wr   = (state_q == IDLE) & slot_full_q;
  assign issue_rd   = (state_q == IDLE) & ~slot_full_q & fetch_en & ~fifo_full;
  assign rd_done    = (state_q == RD_WAIT) & mem_ack;
  // A read issued before a restart (older epoch) or completing while fetch is off is dropped.
  assign push       = rd_done & (rd_epoch_q == epoch_q) & fetch_en & ~restart;
  assign pop        = consume & ~fifo_empty & half_q;
  assign flush      = ~fetch_en | restart;
  assign head       = fifo_mem[rd_ptr_q];

  always_comb begin
    count_d = count_q;
    if (push & ~pop)
      count_d = count_q + (PW+1)'(1);
    else if (pop & ~push)
      count_d = count_q - (PW+1)'(1);
  end

  always_ff @(posedge clk) begin
    if (push)
      fifo_mem[wr_ptr_q] <= mem_dout;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      use_bg_q     <= 1'b0;
      vsync_q      <= 1'b0;
      epoch_q      <= 1'b0;
      rd_epoch_q   <= 1'b0;
      half_q       <= 1'b0;
      lat_q        <= '0;
      slot_full_q  <= 1'b0;
      slot_addr_q  <= '0;
      slot_data_q  <= '0;
      fetch_addr_q <= '0;
      mem_addr_q   <= '0;
      mem_din_q    <= '0;
      mem_req_q    <= 1'b0;
      mem_rnw_q    <= 1'b0;
      pix_q        <= '0;
      underrun_q   <= 1'b0;
      dl_overrun_q <= 1'b0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
    end else begin
      vsync_q   <= vsync;
      mem_req_q <= 1'b0;
      if (dl_active & sdram_present)
        use_bg_q <= 1'b1;
      if (dl_wr & ~dl_addr[0])
        lat_q <= dl_data;

      // The slot frees as soon as its write is handed to the channel registers.
      if (new_wr & slot_full_q & ~issue_wr) begin
        dl_overrun_q <= 1'b1;
      end else if (new_wr) begin
        slot_full_q <= 1'b1;
        slot_addr_q <= ADDR_W'(dl_addr[24:1]);
        slot_data_q <= {dl_data, lat_q};
      end else if (issue_wr) begin
        slot_full_q <= 1'b0;
      end

      case (state_q)
        IDLE: begin
          if (issue_wr) begin
            mem_req_q  <= 1'b1;
            mem_rnw_q  <= 1'b0;
            mem_addr_q <= slot_addr_q;
            mem_din_q  <= slot_data_q;
            state_q    <= WR_WAIT;
          end else if (issue_rd) begin
            mem_req_q  <= 1'b1;
            mem_rnw_q  <= 1'b1;
            mem_addr_q <= fetch_addr_q;
            rd_epoch_q <= epoch_q;
            state_q    <= RD_WAIT;
          end
        end
        WR_WAIT: if (mem_ack) state_q <= IDLE;
        RD_WAIT: if (mem_ack) state_q <= IDLE;
        default: state_q <= IDLE;
      endcase

      if (flush) begin
        wr_ptr_q     <= '0;
        rd_ptr_q     <= '0;
        count_q      <= '0;
        half_q       <= 1'b0;
        fetch_addr_q <= '0;
      end else begin
        if (push) begin
          wr_ptr_q     <= wr_ptr_q + PW'(1);
          fetch_addr_q <= fetch_addr_q + ADDR_W'(2);
        end
        if (pop)
          rd_ptr_q <= rd_ptr_q + PW'(1);
        count_q <= count_d;
        if (pop)
          half_q <= 1'b0;
        else if (consume & ~fifo_empty)
          half_q <= 1'b1;
      end

      if (restart) begin
        epoch_q    <= ~epoch_q;
        underrun_q <= 1'b0;
      end else if (consume & fifo_empty) begin
        underrun_q <= 1'b1;
      end

      if (~fetch_en)
        pix_q <= '0;
      else if (consume)
        pix_q <= fifo_empty ? 16'h0 : (half_q ? head[31:16] : head[15:0]);
    end
  end

  assign mem_addr   = mem_addr_q;
  assign mem_din    = mem_din_q;
  assign mem_req    = mem_req_q;
  assign mem_rnw    = mem_rnw_q;
  assign use_bg     = use_bg_q;
  assign pix_out    = pix_q;
  assign underrun   = underrun_q;
  assign dl_overrun = dl_overrun_q;
endmodule

// File: tb/tb_overlay_sdram_sched.sv
// Randomized bench for overlay_sdram_sched: a queue-based reference model of the fetch
// stream and write slot, plus a memory responder with random or forced ack latency.
module tb_overlay_sdram_sched;
  localparam int AW    = 24;
  localparam int DEPTH = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset = 1'b1, sdram_present = 1'b0, dl_active = 1'b0, dl_wr = 1'b0;
  logic [24:0]   dl_addr = '0;
  logic [7:0]    dl_data = '0;
  logic          ce_pix = 1'b0, hblank = 1'b0, vblank = 1'b0, vsync = 1'b0;
  logic [AW-1:0] mem_addr;
  logic [15:0]   mem_din;
  logic          mem_req, mem_rnw;
  logic [31:0]   mem_dout = '0;
  logic          mem_ack = 1'b0;
  logic          use_bg, underrun, dl_overrun;
  logic [15:0]   pix_out;

  overlay_sdram_sched #(.ADDR_W(AW), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .sdram_present(sdram_present), .dl_active(dl_active),
    .dl_wr(dl_wr), .dl_addr(dl_addr), .dl_data(dl_data), .ce_pix(ce_pix),
    .hblank(hblank), .vblank(vblank), .vsync(vsync), .mem_addr(mem_addr),
    .mem_din(mem_din), .mem_req(mem_req), .mem_rnw(mem_rnw), .mem_dout(mem_dout),
    .mem_ack(mem_ack), .use_bg(use_bg), .pix_out(pix_out), .underrun(underrun),
    .dl_overrun(dl_overrun)
  );

  int total = 0;
  int bad   = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  // bench-side SDRAM contents and responder
  logic [15:0]   bmem [512];
  int            resp_lat = 0;
  int            ack_cnt  = 0;
  logic [AW-1:0] resp_addr = '0;
  logic          resp_rnw  = 1'b0;

  // reference model state
  bit            m_use_bg, m_vs_prev, m_busy, m_busy_rd, m_slot_full, m_ovr, m_under, m_half;
  logic [AW-1:0] m_addr = '0, m_rd_addr = '0, m_slot_addr = '0, m_req_addr = '0;
  logic [15:0]   m_slot_data = '0, m_pix = '0;
  logic [7:0]    m_lat = '0;
  int            m_frame = 0, m_rd_frame = 0;
  logic [31:0]   m_q [$];
  logic [39:0]   wr_log [$];
  int            wr_seen = 0;

  // inputs as seen by the active edge
  logic          c_reset, c_sdram, c_dla, c_wr, c_ce, c_hb, c_vb, c_vs, c_ack;
  logic [24:0]   c_addr;
  logic [7:0]    c_data;

  initial begin
    bit          fen, rise, cons, iss_wr, iss_rd, push, adv;
    logic [31:0] pdata, hd;
    logic [8:0]  ia, ib;
    forever begin
      @(posedge clk);
      c_reset = reset; c_sdram = sdram_present; c_dla = dl_active; c_wr = dl_wr;
      c_addr = dl_addr; c_data = dl_data; c_ce = ce_pix; c_hb = hblank; c_vb = vblank;
      c_vs = vsync; c_ack = mem_ack;
      #1;
      if (c_reset) begin
        m_use_bg = 0; m_vs_prev = 0; m_busy = 0; m_slot_full = 0; m_ovr = 0;
        m_under = 0; m_half = 0; m_addr = '0; m_pix = '0; m_lat = '0; m_frame = 0;
        m_q.delete();
        check_val("rst_req", mem_req, 0);
      end else begin
        fen    = m_use_bg & ~c_dla;
        rise   = c_vs & ~m_vs_prev & fen;
        cons   = c_ce & ~c_hb & ~c_vb & fen;
        iss_wr = ~m_busy & m_slot_full;
        iss_rd = ~m_busy & ~m_slot_full & fen & (m_q.size() < DEPTH);
        check_val("req", mem_req, iss_wr | iss_rd);
        if (mem_req && !mem_rnw) begin
          wr_log.push_back({16'(mem_addr), mem_din});
          wr_seen++;
        end
        if (iss_wr) begin
          check_val("wr_rnw", mem_rnw, 0);
          check_val("wr_addr", mem_addr, m_slot_addr);
          check_val("wr_data", mem_din, m_slot_data);
        end else if (iss_rd) begin
          check_val("rd_rnw", mem_rnw, 1);
          check_val("rd_addr", mem_addr, m_addr);
        end else if (m_busy) begin
          check_val("hold_addr", mem_addr, m_req_addr);
          check_val("hold_rnw", mem_rnw, m_busy_rd);
        end
        push = 0; adv = 0; pdata = '0;
        if (c_ack && m_busy) begin
          if (m_busy_rd && fen && !rise && m_rd_frame == m_frame) begin
            ia = m_rd_addr[8:0];
            ib = ia + 9'd1;
            pdata = {bmem[ib], bmem[ia]};
            push = 1; adv = 1;
          end
          m_busy = 0;
        end
        if (iss_wr || iss_rd) begin
          m_busy = 1; m_busy_rd = iss_rd; m_rd_frame = m_frame; m_rd_addr = m_addr;
          m_req_addr = iss_wr ? m_slot_addr : m_addr;
        end
        if (!fen) m_pix = '0;
        else if (cons) begin
          if (m_q.size() == 0) begin
            m_pix = '0;
            m_under = 1;
          end else begin
            hd = m_q[0];
            m_pix = m_half ? hd[31:16] : hd[15:0];
            if (m_half) begin
              m_q.delete(0);
              m_half = 0;
            end else m_half = 1;
          end
        end
        if (!fen || rise) begin
          m_q.delete(); m_addr = '0; m_half = 0;
        end else begin
          if (push) m_q.push_back(pdata);
          if (adv) m_addr = m_addr + 24'd2;
        end
        if (rise) begin m_frame++; m_under = 0; end
        if (c_wr && c_addr[0]) begin
          if (m_slot_full && !iss_wr) m_ovr = 1;
          else begin
            m_slot_full = 1; m_slot_addr = c_addr[24:1]; m_slot_data = {c_data, m_lat};
          end
        end else if (iss_wr) m_slot_full = 0;
        if (c_wr && !c_addr[0]) m_lat = c_data;
        if (c_dla && c_sdram) m_use_bg = 1;
        m_vs_prev = c_vs;
      end
      check_val("pix", pix_out, m_pix);
      check_val("underrun", underrun, m_under);
      check_val("use_bg", use_bg, m_use_bg);
      check_val("dl_overrun", dl_overrun, m_ovr);

      mem_ack = 1'b0;
      if (mem_req) begin
        ack_cnt   = (resp_lat > 0) ? resp_lat : int'($urandom_range(1, 6));
        resp_addr = mem_addr;
        resp_rnw  = mem_rnw;
        if (!mem_rnw) bmem[mem_addr[8:0]] = mem_din;
      end
      if (ack_cnt > 0) begin
        ack_cnt--;
        if (ack_cnt == 0) begin
          ia = resp_addr[8:0];
          ib = ia + 9'd1;
          mem_ack  = 1'b1;
          mem_dout = resp_rnw ? {bmem[ib], bmem[ia]} : $urandom;
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic vs_pulse();
    vsync = 1'b1; tick(); tick();
    vsync = 1'b0; tick();
  endtask

  task automatic send_pair(input logic [24:0] a, input logic [7:0] lo, input logic [7:0] hi);
    dl_wr = 1'b1; dl_addr = a; dl_data = lo; tick();
    dl_addr = a | 25'd1; dl_data = hi; tick();
    dl_wr = 1'b0;
  endtask

  task automatic wait_read(input string tag, input logic [AW-1:0] exp_addr);
    int n;
    n = 0;
    while (!(mem_req && mem_rnw) && n < 60) begin tick(); n++; end
    if (n >= 60) check_val({tag, "_timeout"}, 0, 1);
    else check_val(tag, mem_addr, exp_addr);
  endtask

  initial begin
    int w0, vs_timer, vs_hold;
    for (int i = 0; i < 512; i++) bmem[i] = 16'($urandom);

    sdram_present = 1'b1;
    repeat (3) tick();
    reset = 1'b0;
    check_val("rst_mem_addr", mem_addr, 0);
    check_val("rst_mem_din", mem_din, 0);
    check_val("rst_mem_rnw", mem_rnw, 0);
    check_val("rst_pix", pix_out, 0);

    // download: fixed first pairs, then random pairs with no slot pressure
    dl_active = 1'b1; tick();
    send_pair(25'd0, 8'h11, 8'h22);
    repeat (10) tick();
    send_pair(25'd2, 8'h33, 8'h44);
    repeat (10) tick();
    for (int p = 0; p < 6; p++) begin
      send_pair(25'($urandom_range(2, 200) * 2), 8'($urandom), 8'($urandom));
      repeat (10) tick();
    end
    check_val("dl_wr0_addr", wr_log[0][39:16], 0);
    check_val("dl_wr0_data", wr_log[0][15:0], 16'h2211);
    check_val("dl_wr1_addr", wr_log[1][39:16], 1);
    check_val("dl_wr1_data", wr_log[1][15:0], 16'h4433);
    check_val("dl_use_bg", use_bg, 1);
    check_val("dl_no_overrun", dl_overrun, 0);

    // back-to-back pairs against a slow channel: one issued, one held, one dropped
    resp_lat = 20;
    w0 = wr_seen;
    for (int p = 0; p < 3; p++)
      send_pair(25'(300 + p * 2), 8'($urandom), 8'($urandom));
    repeat (60) tick();
    resp_lat = 0;
    check_val("ovr_writes", wr_seen - w0, 2);
    check_val("ovr_flag", dl_overrun, 1);

    // fetch start: word 0 preloaded, two active pixels read its halves
    bmem[0] = 16'hAAAA;
    bmem[1] = 16'hBBBB;
    dl_active = 1'b0;
    repeat (4) tick();
    vs_pulse();
    repeat (30) tick();
    ce_pix = 1'b1; tick(); ce_pix = 1'b0;
    check_val("pix_lo", pix_out, 16'hAAAA);
    tick();
    ce_pix = 1'b1; tick(); ce_pix = 1'b0;
    check_val("pix_hi", pix_out, 16'hBBBB);
    repeat (10) tick();

    // starve the FIFO: slow reads after a restart
    resp_lat = 40;
    vs_pulse();
    for (int k = 0; k < 4; k++) begin
      ce_pix = 1'b1; tick(); ce_pix = 1'b0;
      check_val("starve_pix", pix_out, 0);
      repeat (7) tick();
    end
    check_val("starve_underrun", underrun, 1);
    repeat (60) tick();
    resp_lat = 0;
    vsync = 1'b1; tick();
    check_val("vs_clears_underrun", underrun, 0);
    tick(); vsync = 1'b0; tick();

    // randomized video timing with periodic vsync and one download burst
    vs_timer = 80; vs_hold = 0;
    for (int cyc = 0; cyc < 2500; cyc++) begin
      ce_pix = ($urandom_range(0, 2) == 0);
      hblank = ((cyc % 40) >= 32);
      vblank = (vs_timer < 10);
      dl_active = (cyc >= 1200 && cyc < 1230);
      if (vs_hold > 0) begin
        vsync = 1'b1; vs_hold--;
      end else begin
        vsync = 1'b0;
        if (vs_timer == 0) begin
          vs_hold = 3; vs_timer = $urandom_range(60, 150);
        end else vs_timer--;
      end
      tick();
    end
    ce_pix = 1'b0; hblank = 1'b0; vblank = 1'b0; vsync = 1'b0; dl_active = 1'b0;
    tick();

    // reset while a read is outstanding; its late ack must be ignored
    resp_lat = 5;
    wait_read("pre_rst_read", mem_addr);
    reset = 1'b1; tick(); reset = 1'b0;
    check_val("mid_rst_addr", mem_addr, 0);
    check_val("mid_rst_rnw", mem_rnw, 0);
    check_val("mid_rst_use_bg", use_bg, 0);
    check_val("mid_rst_ovr", dl_overrun, 0);
    repeat (10) tick();
    resp_lat = 0;
    check_val("post_rst_idle_req", mem_req, 0);
    dl_active = 1'b1; tick(); dl_active = 1'b0;
    wait_read("post_rst_read", 0);
    vs_pulse();
    for (int k = 0; k < 40; k++) begin
      ce_pix = (k % 3 == 0); tick();
    end
    ce_pix = 1'b0;
    repeat (5) tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
